// File: rtl/qvga_fb_arbiter.sv
// qvga_fb_arbiter: shares one single-port 320x240x12 frame buffer between a
// display reader (strict priority) and a camera writer fed through a 4-entry
// write FIFO. Reads return rd_data two cycles after rd_req.
// Handshake: rd_req is sampled every cycle with no back-pressure; each cycle
// with rd_req=1 yields exactly one rd_valid=1 cycle two cycles later.
// Optional feature: define QVGA_FB_ARBITER_DROP_CNT_EN to add the drop_cnt
// output (saturating count of dropped camera pixels per frame).
module qvga_fb_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cam_vsync,
    input  logic        cam_we,
    input  logic [11:0] cam_wdata,
    input  logic        rd_req,
    input  logic [16:0] rd_addr,
    output logic        rd_valid,
    output logic [11:0] rd_data,
    output logic        mem_en,
    output logic        mem_we,
    output logic [16:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata,
    output logic        wr_overflow,
    output logic        frame_done
`ifdef QVGA_FB_ARBITER_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    localparam logic [16:0] LAST_ADDR    = 17'd76799;
    localparam logic [16:0] FRAME_PIXELS = 17'd76800;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_e;

    state_e      state_q, state_d;

    logic        vsync_q;
    logic        vsync_rise;
    logic [16:0] cnt_q, cnt_d, cnt_base;
    logic        overflow_q, overflow_d;

    logic [16:0] fifo_addr_q [4];
    logic [11:0] fifo_data_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q, count_d;
    logic        fifo_empty, fifo_full;
    logic        push, pop, drop;

    logic        mem_en_q, mem_we_q;
    logic [16:0] mem_addr_q;
    logic [11:0] mem_wdata_q;
    logic        frame_done_q;
    logic        rd_valid_q;

    assign vsync_rise = cam_vsync & ~vsync_q;
    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);

    // Grant decision, counter/overflow next state and FIFO push/pop qualifiers
    always_comb begin
        state_d = IDLE;
        if (rd_req) begin
            state_d = RD;
        end else if (!fifo_empty) begin
            state_d = WR;
        end
        pop = (state_d == WR);

        // A vsync edge restarts the frame before this cycle's pixel is numbered
        cnt_base = vsync_rise ? 17'd0 : cnt_q;
        // A full FIFO still accepts a pixel when the head leaves this cycle
        push = cam_we && (cnt_base < FRAME_PIXELS) && (!fifo_full || pop);
        drop = cam_we && !push;
        cnt_d = push ? (cnt_base + 17'd1) : cnt_base;

        overflow_d = overflow_q;
        if (vsync_rise) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Vsync edge register, pixel counter, sticky overflow and FIFO pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q    <= 1'b0;
            cnt_q      <= 17'd0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
        end else begin
            vsync_q    <= cam_vsync;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
        end
    end

    // FIFO storage; contents are meaningless unless covered by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= cnt_base;
            fifo_data_q[wr_ptr_q] <= cam_wdata;
        end
    end

    // Grant FSM with registered memory-side outputs for the granted access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 17'd0;
            mem_wdata_q  <= 12'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= 1'b0;
            case (state_d)
                RD: begin
                    mem_en_q    <= 1'b1;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= rd_addr;
                    mem_wdata_q <= 12'd0;
                end
                WR: begin
                    mem_en_q     <= 1'b1;
                    mem_we_q     <= 1'b1;
                    mem_addr_q   <= fifo_addr_q[rd_ptr_q];
                    mem_wdata_q  <= fifo_data_q[rd_ptr_q];
                    frame_done_q <= (fifo_addr_q[rd_ptr_q] == LAST_ADDR);
                end
                default: begin
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= 17'd0;
                    mem_wdata_q <= 12'd0;
                end
            endcase
        end
    end

    // Read return: the RD cycle presents the address, memory answers one cycle later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= (state_q == RD);
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign frame_done  = frame_done_q;
    assign wr_overflow = overflow_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_valid_q ? mem_rdata : 12'd0;

`ifdef QVGA_FB_ARBITER_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    // Saturating per-frame count of dropped pixels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= 16'd0;
        end else if (vsync_rise) begin
            drop_cnt_q <= drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_qvga_fb_arbiter.sv
// Directed bench for qvga_fb_arbiter with a 1-cycle synchronous memory model.
// Stimulus pushes expected memory writes and read returns into queues; a
// negedge monitor pops and compares whenever the DUT writes or returns data.
module tb_qvga_fb_arbiter;

    logic        clk;
    logic        reset_n;
    logic        cam_vsync;
    logic        cam_we;
    logic [11:0] cam_wdata;
    logic        rd_req;
    logic [16:0] rd_addr;
    logic        rd_valid;
    logic [11:0] rd_data;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic        wr_overflow;
    logic        frame_done;
`ifdef QVGA_FB_ARBITER_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int total;
    int bad;
    int fd_count;

    logic [28:0] exp_wr_q[$];
    logic [11:0] exp_rd_q[$];

    logic [11:0] mem_model [76800];

    qvga_fb_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cam_vsync   (cam_vsync),
        .cam_we      (cam_we),
        .cam_wdata   (cam_wdata),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .wr_overflow (wr_overflow),
        .frame_done  (frame_done)
`ifdef QVGA_FB_ARBITER_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous frame buffer
    initial begin
        mem_rdata = 12'd0;
        for (int i = 0; i < 76800; i++) begin
            mem_model[i] = 12'd0;
        end
        mem_model[100] = 12'hABC;
    end

    always @(posedge clk) begin
        if (mem_en && mem_we && mem_addr < 17'd76800) begin
            mem_model[mem_addr] <= mem_wdata;
        end else if (mem_en && mem_addr < 17'd76800) begin
            mem_rdata <= mem_model[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        cam_vsync = 1'b0;
        cam_we    = 1'b0;
        cam_wdata = 12'd0;
        rd_req    = 1'b0;
        rd_addr   = 17'd0;
    endtask

    // Wait (bounded) until every expected write and read has been observed
    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_wr_q.size() == 0 && exp_rd_q.size() == 0) break;
            tick();
        end
        check("drain_wr_left", exp_wr_q.size(), 0);
        check("drain_rd_left", exp_rd_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"},      mem_en, 0);
        check({tag, "_mem_we"},      mem_we, 0);
        check({tag, "_mem_addr"},    mem_addr, 0);
        check({tag, "_mem_wdata"},   mem_wdata, 0);
        check({tag, "_rd_valid"},    rd_valid, 0);
        check({tag, "_rd_data"},     rd_data, 0);
        check({tag, "_wr_overflow"}, wr_overflow, 0);
        check({tag, "_frame_done"},  frame_done, 0);
`ifdef QVGA_FB_ARBITER_DROP_CNT_EN
        check({tag, "_drop_cnt"},    drop_cnt, 0);
`endif
    endtask

    // Monitor: compare every memory write and read return against the queues
    always @(negedge clk) begin
        if (mem_en && mem_we) begin
            total++;
            if (exp_wr_q.size() == 0) begin
                bad++;
                $display("FAIL mem_write_unexpected: got addr=%0d data=%h expected none", mem_addr, mem_wdata);
            end else begin
                logic [28:0] e;
                e = exp_wr_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    bad++;
                    $display("FAIL mem_write: got addr=%0d data=%h expected addr=%0d data=%h",
                             mem_addr, mem_wdata, e[28:12], e[11:0]);
                end
            end
        end
        if (rd_valid) begin
            total++;
            if (exp_rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_valid_unexpected: got data=%h expected none", rd_data);
            end else begin
                logic [11:0] r;
                r = exp_rd_q.pop_front();
                if (rd_data !== r) begin
                    bad++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, r);
                end
            end
        end
        if (frame_done) begin
            fd_count++;
            total++;
            if (!(mem_we && mem_addr == 17'd76799)) begin
                bad++;
                $display("FAIL frame_done_pos: got we=%0b addr=%0d expected we=1 addr=76799", mem_we, mem_addr);
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        fd_count = 0;
        reset_n  = 1'b0;
        drive_idle();

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        tick();
        reset_n = 1'b1;
        tick();

        // Vsync edge, then three pixels written to 0,1,2 in order
        cam_vsync = 1'b1;
        tick();
        cam_vsync = 1'b0;
        cam_we = 1'b1; cam_wdata = 12'hF00; exp_wr_q.push_back({17'd0, 12'hF00});
        tick();
        cam_wdata = 12'h0F0; exp_wr_q.push_back({17'd1, 12'h0F0});
        tick();
        cam_wdata = 12'h00F; exp_wr_q.push_back({17'd2, 12'h00F});
        tick();
        cam_we = 1'b0;
        wait_drain(20);
        @(negedge clk);
        check("s1_overflow", wr_overflow, 0);

        // Read wins over a pending write; write follows on the first idle-read cycle
        tick();
        cam_we = 1'b1; cam_wdata = 12'h123; exp_wr_q.push_back({17'd3, 12'h123});
        tick();
        cam_we = 1'b0;
        rd_req = 1'b1; rd_addr = 17'd100; exp_rd_q.push_back(12'hABC);
        tick();
        rd_req = 1'b0;
        @(negedge clk);
        check("s2_rd_en",   mem_en, 1);
        check("s2_rd_we",   mem_we, 0);
        check("s2_rd_addr", mem_addr, 100);
        tick();
        @(negedge clk);
        check("s2_wr_we",     mem_we, 1);
        check("s2_wr_addr",   mem_addr, 3);
        check("s2_rd_valid",  rd_valid, 1);
        check("s2_rd_data",   rd_data, 12'hABC);
        wait_drain(20);

        // Reads starve writes: 6 pixels, 4 fit in the FIFO, 2 dropped
        tick();
        rd_req = 1'b1; rd_addr = 17'd100;
        for (int i = 0; i < 6; i++) begin
            cam_we = 1'b1;
            cam_wdata = 12'h101 + 12'(i);
            exp_rd_q.push_back(12'hABC);
            tick();
        end
        cam_we = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        check("s3_overflow", wr_overflow, 1);
`ifdef QVGA_FB_ARBITER_DROP_CNT_EN
        check("s3_drop_cnt", drop_cnt, 2);
`endif
        exp_wr_q.push_back({17'd4, 12'h101});
        exp_wr_q.push_back({17'd5, 12'h102});
        exp_wr_q.push_back({17'd6, 12'h103});
        exp_wr_q.push_back({17'd7, 12'h104});
        wait_drain(20);

        // Full frame of 76801 pixels: one frame_done, last pixel dropped
        tick();
        cam_vsync = 1'b1;
        tick();
        cam_vsync = 1'b0;
        @(negedge clk);
        check("s4_overflow_cleared", wr_overflow, 0);
        fd_count = 0;
        tick();
        for (int i = 0; i < 76801; i++) begin
            cam_we = 1'b1;
            cam_wdata = 12'(i);
            if (i < 76800) exp_wr_q.push_back({17'(i), 12'(i)});
            tick();
        end
        cam_we = 1'b0;
        wait_drain(20);
        check("s4_frame_done_count", fd_count, 1);
        check("s4_overflow", wr_overflow, 1);
`ifdef QVGA_FB_ARBITER_DROP_CNT_EN
        check("s4_drop_cnt", drop_cnt, 1);
`endif

        // Vsync edge together with a pixel: pixel gets address 0, next gets 1
        tick();
        cam_vsync = 1'b1; cam_we = 1'b1; cam_wdata = 12'h5A5;
        exp_wr_q.push_back({17'd0, 12'h5A5});
        tick();
        cam_wdata = 12'h3C3;
        exp_wr_q.push_back({17'd1, 12'h3C3});
        tick();
        cam_vsync = 1'b0; cam_we = 1'b0;
        @(negedge clk);
        check("s5_overflow_cleared", wr_overflow, 0);
`ifdef QVGA_FB_ARBITER_DROP_CNT_EN
        check("s5_drop_cnt", drop_cnt, 0);
`endif
        wait_drain(20);

        // Reset with three entries queued and reads in flight
        tick();
        rd_req = 1'b1; rd_addr = 17'd200;
        exp_rd_q.push_back(12'h0C8);
        cam_we = 1'b1; cam_wdata = 12'h111;
        tick();
        cam_wdata = 12'h222;
        tick();
        cam_wdata = 12'h333;
        tick();
        reset_n = 1'b0;
        drive_idle();
        @(negedge clk);
        check_all_zero("s6_in_reset");
        tick();
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check_all_zero("s6_after_reset");
        check("s6_wr_left", exp_wr_q.size(), 0);
        check("s6_rd_left", exp_rd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
